// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the I/D memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned DEF_AW = 32;
  localparam int unsigned DEF_DW = 32;
  // Wide enough for RD_LAT - 1 with RD_LAT up to 7.
  localparam int unsigned LAT_W  = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_arb_select.sv
// Winner selection for the memory arbiter: D has priority, but after MAX_DGRANT
// consecutive D grants with a fetch waiting, the fetch is forced through.
module mem_port_arbiter_arb_select
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DGRANT = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  logic   i_req,
  input  logic   d_req,
  output logic   i_win,
  output logic   d_win,
  output owner_t win_own
);

  localparam int unsigned CW = $clog2(MAX_DGRANT + 1);
  localparam logic [CW-1:0] DMAX = CW'(MAX_DGRANT);

  logic [CW-1:0] dcount_q, dcount_d;
  logic          starve;

  // Combinational winner; nothing wins unless the arbiter is able to issue.
  always_comb begin
    starve  = i_req && (dcount_q == DMAX);
    d_win   = en && d_req && !starve;
    i_win   = en && i_req && !d_win;
    win_own = d_win ? OWN_D : OWN_I;
  end

  // Consecutive D grants seen by a waiting fetch; any gap in i_req forgets them.
  always_comb begin
    dcount_d = dcount_q;
    if (!i_req || i_win) begin
      dcount_d = '0;
    end else if (d_win && (dcount_q != DMAX)) begin
      dcount_d = dcount_q + CW'(1);
    end
  end

  // dcount register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dcount_q <= '0;
    end else begin
      dcount_q <= dcount_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (I) and load/store (D).
// Reads return with fixed latency RD_LAT + 1 from grant; stores complete at grant.
// Optional build macro ARB_PERF_EN adds per-port stall cycle counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW         = DEF_AW,
  parameter int unsigned DW         = DEF_DW,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned MAX_DGRANT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]   perf_i_stall,
  output logic [31:0]   perf_d_stall
`endif
);

  state_t           state_q, state_d;
  owner_t           owner_q, owner_d, win_own;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             idle, i_win, d_win, rd_done;
  logic             i_rvalid_q, d_rvalid_q;
  logic [DW-1:0]    i_rdata_q, d_rdata_q;

  // Grants are suppressed while reset is asserted so every output reads 0.
  always_comb begin
    idle = (state_q == IDLE) && rst;
  end

  mem_port_arbiter_arb_select #(
    .MAX_DGRANT(MAX_DGRANT)
  ) u_arb_select (
    .clk    (clk),
    .rst    (rst),
    .en     (idle),
    .i_req  (i_req),
    .d_req  (d_req),
    .i_win  (i_win),
    .d_win  (d_win),
    .win_own(win_own)
  );

  // Next state, latency countdown and memory-side muxing.
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    owner_d   = owner_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rd_done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_win || d_win) begin
          mem_en   = 1'b1;
          mem_addr = (win_own == OWN_D) ? d_addr : i_addr;
          if (d_win && d_we) begin
            mem_we    = 1'b1;
            mem_wdata = d_wdata;
          end else begin
            state_d = RD_WAIT;
            lat_d   = LAT_W'(RD_LAT - 1);
            owner_d = win_own;
          end
        end
      end
      RD_WAIT: begin
        if (lat_q == '0) begin
          rd_done = 1'b1;
          state_d = IDLE;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, owner and latency registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      lat_q   <= lat_d;
    end
  end

  // Read data capture; each rdata register holds until its port's next read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      i_rvalid_q <= rd_done && (owner_q == OWN_I);
      d_rvalid_q <= rd_done && (owner_q == OWN_D);
      if (rd_done && (owner_q == OWN_I)) i_rdata_q <= mem_rdata;
      if (rd_done && (owner_q == OWN_D)) d_rdata_q <= mem_rdata;
    end
  end

`ifdef ARB_PERF_EN
  // Stall counters: cycles with a request pending and no grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_i_stall <= '0;
      perf_d_stall <= '0;
    end else begin
      if (i_req && !i_win) perf_i_stall <= perf_i_stall + 32'd1;
      if (d_req && !d_win) perf_d_stall <= perf_d_stall + 32'd1;
    end
  end
`endif

  assign i_gnt    = i_win;
  assign d_gnt    = d_win;
  assign i_rvalid = i_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule
